// File: rtl/game_pkg.sv
// Shared digit constants, FSM state encoding and width helpers for the A/B game engine.
package game_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_SCORE = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ab_history_buf.sv
// Circular record of scored guesses; write lands on the score edge, reads are combinational.
// Index 0 is the newest entry; indices at or beyond the fill count read as zero.
module ab_history_buf
  import game_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 24,
  localparam int IW    = idx_w(DEPTH),
  localparam int CNTW  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdat,
  input  logic [IW-1:0]     i_idx,
  output logic [DATA_W-1:0] o_rdat,
  output logic [CNTW-1:0]   o_cnt
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IW-1:0]     r_wp;
  logic [CNTW-1:0]   r_cnt;
  logic [IW-1:0]     w_slot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (i_we) begin
      r_mem[r_wp] <= i_wdat;
      r_wp        <= r_wp + IW'(1);
      if (r_cnt != CNTW'(DEPTH)) r_cnt <= r_cnt + CNTW'(1);
    end
  end

  // Power-of-two depth lets the pointer arithmetic wrap for free.
  assign w_slot = r_wp - IW'(1) - i_idx;
  assign o_rdat = (CNTW'(i_idx) < r_cnt) ? r_mem[w_slot] : '0;
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/ab_game_engine.sv
// A/B game engine: legality check, serial one-digit-per-cycle scorer, try counter; score NUM_DIGITS+1 cycles after accept.
// o_ready only in IDLE/PLAY (no queueing); GAME_HISTORY_EN adds a guess history buffer, else o_hist_* read 0.
module ab_game_engine
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_TRIES  = 10,
  parameter int HIST_DEPTH = 8,
  localparam int DW  = DIGIT_W * NUM_DIGITS,
  localparam int CW  = cnt_w(NUM_DIGITS),
  localparam int TW  = cnt_w(MAX_TRIES),
  localparam int HIW = idx_w(HIST_DEPTH),
  localparam int HCW = cnt_w(HIST_DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [DW-1:0]  i_digits,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_restart,
  output logic [2:0]     o_state,
  output logic           o_reject,
  output logic           o_score_valid,
  output logic [CW-1:0]  o_score_a,
  output logic [CW-1:0]  o_score_b,
  output logic [TW-1:0]  o_tries,
  output logic           o_win,
  output logic           o_lose,
  input  logic [HIW-1:0] i_hist_idx,
  output logic [DW-1:0]  o_hist_digits,
  output logic [CW-1:0]  o_hist_a,
  output logic [CW-1:0]  o_hist_b,
  output logic [HCW-1:0] o_hist_cnt
);
  state_t        r_state;
  logic [DW-1:0] r_secret, r_guess;
  logic [CW-1:0] r_k, r_acc_a, r_acc_b, r_score_a, r_score_b;
  logic [TW-1:0] r_tries;
  logic          r_reject, r_score_vld;

  logic               w_legal, w_in_secret, w_k_last;
  logic [DIGIT_W-1:0] w_g_dig, w_s_dig;

  always_comb begin
    w_legal = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i_digits[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX) w_legal = 1'b0;
      for (int j = i + 1; j < NUM_DIGITS; j++)
        if (i_digits[i*DIGIT_W +: DIGIT_W] == i_digits[j*DIGIT_W +: DIGIT_W]) w_legal = 1'b0;
    end
  end

  // Digit pair under the scan index; r_k == NUM_DIGITS is the publish cycle.
  always_comb begin
    w_g_dig     = '0;
    w_s_dig     = '0;
    w_in_secret = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_k == CW'(i)) begin
        w_g_dig = r_guess[i*DIGIT_W +: DIGIT_W];
        w_s_dig = r_secret[i*DIGIT_W +: DIGIT_W];
      end
    end
    for (int j = 0; j < NUM_DIGITS; j++)
      if (r_secret[j*DIGIT_W +: DIGIT_W] == w_g_dig) w_in_secret = 1'b1;
  end

  assign w_k_last = (r_k == CW'(NUM_DIGITS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_secret    <= '0;
      r_guess     <= '0;
      r_k         <= '0;
      r_acc_a     <= '0;
      r_acc_b     <= '0;
      r_score_a   <= '0;
      r_score_b   <= '0;
      r_tries     <= '0;
      r_reject    <= 1'b0;
      r_score_vld <= 1'b0;
    end else begin
      r_reject    <= 1'b0;
      r_score_vld <= 1'b0;
      if (i_restart) begin
        r_state   <= ST_IDLE;
        r_secret  <= '0;
        r_guess   <= '0;
        r_k       <= '0;
        r_acc_a   <= '0;
        r_acc_b   <= '0;
        r_score_a <= '0;
        r_score_b <= '0;
        r_tries   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_valid) begin
              if (w_legal) begin
                r_secret <= i_digits;
                r_state  <= ST_PLAY;
              end else begin
                r_reject <= 1'b1;
              end
            end
          end
          ST_PLAY: begin
            if (i_valid) begin
              if (w_legal) begin
                r_guess <= i_digits;
                r_k     <= '0;
                r_acc_a <= '0;
                r_acc_b <= '0;
                r_state <= ST_SCORE;
              end else begin
                r_reject <= 1'b1;
              end
            end
          end
          ST_SCORE: begin
            if (w_k_last) begin
              r_score_a   <= r_acc_a;
              r_score_b   <= r_acc_b;
              r_score_vld <= 1'b1;
              r_tries     <= r_tries + TW'(1);
              if (r_acc_a == CW'(NUM_DIGITS))             r_state <= ST_WIN;
              else if (r_tries + TW'(1) == TW'(MAX_TRIES)) r_state <= ST_LOSE;
              else                                        r_state <= ST_PLAY;
            end else begin
              if (w_g_dig == w_s_dig)  r_acc_a <= r_acc_a + CW'(1);
              else if (w_in_secret)    r_acc_b <= r_acc_b + CW'(1);
              r_k <= r_k + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_ready       = (r_state == ST_IDLE) || (r_state == ST_PLAY);
  assign o_state       = r_state;
  assign o_reject      = r_reject;
  assign o_score_valid = r_score_vld;
  assign o_score_a     = r_score_a;
  assign o_score_b     = r_score_b;
  assign o_tries       = r_tries;
  assign o_win         = (r_state == ST_WIN);
  assign o_lose        = (r_state == ST_LOSE);

`ifdef GAME_HISTORY_EN
  logic [DW+2*CW-1:0] w_hist_rdat;
  logic               w_hist_we;

  assign w_hist_we = (r_state == ST_SCORE) && w_k_last && !i_restart;

  ab_history_buf #(
    .DEPTH  (HIST_DEPTH),
    .DATA_W (DW + 2*CW)
  ) u_hist (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (i_restart),
    .i_we   (w_hist_we),
    .i_wdat ({r_guess, r_acc_a, r_acc_b}),
    .i_idx  (i_hist_idx),
    .o_rdat (w_hist_rdat),
    .o_cnt  (o_hist_cnt)
  );

  assign {o_hist_digits, o_hist_a, o_hist_b} = w_hist_rdat;
`else
  logic w_unused_hist;
  assign w_unused_hist = ^i_hist_idx;
  assign o_hist_digits = '0;
  assign o_hist_a      = '0;
  assign o_hist_b      = '0;
  assign o_hist_cnt    = '0;
`endif
endmodule
